// File: rtl/counter_pkg.sv
// Shared definitions for the timer controller: FSM state encoding and default width.
package counter_pkg;

    localparam int unsigned CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_t;

endpackage

// File: rtl/timer_ctrl_halfadder.sv
// Single-bit half adder; one stage of the timer's ripple-carry incrementer.
module halfadder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule

// File: rtl/timer_ctrl.sv
// Start/stop/hold timer with captured terminal count, one-shot or auto-restart mode,
// registered tick/done pulses; the increment is a ripple chain of halfadders.
module timer_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             resn,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic [WIDTH-1:0] period,
    input  logic             periodic,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    timer_state_t     r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_period;
    logic             r_periodic;
    logic             r_busy;
    logic             r_tick;
    logic             r_done;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic             w_match;

    for (genvar g = 0; g < WIDTH; g++) begin : g_inc
        if (g == 0) begin : g_lsb
            halfadder u_ha (
                .i_a    (r_cnt[g]),
                .i_b    (1'b1),
                .o_sum  (w_sum[g]),
                .o_carry(w_carry[g])
            );
        end else begin : g_upper
            halfadder u_ha (
                .i_a    (r_cnt[g]),
                .i_b    (w_carry[g-1]),
                .o_sum  (w_sum[g]),
                .o_carry(w_carry[g])
            );
        end
    end

    assign w_match = (r_cnt == r_period);

    always_ff @(posedge clk) begin
        if (!resn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_period   <= '0;
            r_periodic <= 1'b0;
            r_busy     <= 1'b0;
            r_tick     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        r_period   <= period;
                        r_periodic <= periodic;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                // RUN and HOLD share one arm: releasing hold counts on that same edge,
                // so a hold of N cycles delays the next tick by exactly N.
                RUN, HOLD: begin
                    if (stop) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (hold) begin
                        r_state <= HOLD;
                    end else if (w_match) begin
                        r_cnt  <= '0;
                        r_tick <= 1'b1;
                        if (r_periodic) begin
                            r_state <= RUN;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt   <= w_sum;
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cnt  = r_cnt;
    assign busy = r_busy;
    assign tick = r_tick;
    assign done = r_done;

endmodule
